// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns field-level instruction requests into RV32I
// words and writes them one by one into instruction memory through a
// valid/ready write port. Used to preload a program before the core runs.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              err_full
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_LUI  = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [6:0] OPC_REG  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                halt_q, halt_d;
    logic                err_imm_q, err_imm_d;
    logic                err_full_q, err_full_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   enc_word_c;
    logic                imm_ok_c;
    logic                simm12_ok_c;
    logic                jal_ok_c;
    logic [CNT_W-1:0]    count_inc_c;

    // Immediate range qualifiers shared by several ops
    always_comb begin
        simm12_ok_c = (&req_imm[31:11]) || (~|req_imm[31:11]);
        jal_ok_c    = (req_imm[0] == 1'b0) &&
                      ((&req_imm[31:20]) || (~|req_imm[31:20]));
    end

    // Field-to-word encoder and per-op immediate legality
    always_comb begin
        enc_word_c = '0;
        imm_ok_c   = 1'b1;
        unique case (req_op)
            OP_ADD: begin
                enc_word_c = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_REG};
            end
            OP_SUB: begin
                enc_word_c = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_REG};
            end
            OP_LW: begin
                enc_word_c = {req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_LOAD};
                imm_ok_c   = simm12_ok_c;
            end
            OP_SW: begin
                enc_word_c = {req_imm[11:5], req_rs2, req_rs1, 3'b010,
                              req_imm[4:0], OPC_STOR};
                imm_ok_c   = simm12_ok_c;
            end
            OP_ADDI: begin
                enc_word_c = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_IMM};
                imm_ok_c   = simm12_ok_c;
            end
            OP_LUI: begin
                enc_word_c = {req_imm[31:12], req_rd, OPC_LUI};
                imm_ok_c   = (req_imm[11:0] == 12'd0);
            end
            OP_JAL: begin
                enc_word_c = {req_imm[20], req_imm[10:1], req_imm[11],
                              req_imm[19:12], req_rd, OPC_JAL};
                imm_ok_c   = jal_ok_c;
            end
            OP_HALT: begin
                enc_word_c = '0;
            end
            default: begin
                enc_word_c = '0;
            end
        endcase
    end

    // Next-state, datapath updates and registered-output values
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        wdata_d     = wdata_q;
        halt_d      = halt_q;
        err_imm_d   = err_imm_q;
        err_full_d  = err_full_q;
        count_inc_c = count_q + CNT_W'(1);

        if (start) begin
            // Restart wins over everything, including a pending write
            state_d    = S_RUN;
            ptr_d      = '0;
            count_d    = '0;
            halt_d     = 1'b0;
            err_imm_d  = 1'b0;
            err_full_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    if (req_valid) begin
                        if (imm_ok_c) begin
                            wdata_d = enc_word_c;
                            halt_d  = (req_op == OP_HALT);
                            state_d = S_WRITE;
                        end else begin
                            // Illegal immediate: consume the request, write nothing
                            err_imm_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        count_d = count_inc_c;
                        if (halt_q) begin
                            state_d = S_DONE;
                        end else if (count_inc_c == DEPTH_CNT) begin
                            state_d    = S_DONE;
                            err_full_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        req_ready_d = (state_d == S_RUN);
        mem_we_d    = (state_d == S_WRITE);
        busy_d      = (state_d == S_RUN) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            wdata_q     <= '0;
            halt_q      <= 1'b0;
            err_imm_q   <= 1'b0;
            err_full_q  <= 1'b0;
            req_ready_q <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            wdata_q     <= wdata_d;
            halt_q      <= halt_d;
            err_imm_q   <= err_imm_d;
            err_full_q  <= err_full_d;
            req_ready_q <= req_ready_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_imm   = err_imm_q;
    assign err_full  = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-size instance and a
// DEPTH=4 instance share the request/memory inputs; each has its own start.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [4:0]  req_rs1 = 5'd0;
    logic [4:0]  req_rs2 = 5'd0;
    logic [31:0] req_imm = 32'd0;
    logic        mem_ready = 1'b1;

    logic        d0_req_ready, d0_mem_we, d0_busy, d0_done, d0_err_imm, d0_err_full;
    logic [7:0]  d0_mem_addr;
    logic [31:0] d0_mem_wdata;
    logic [8:0]  d0_count;

    logic        d1_req_ready, d1_mem_we, d1_busy, d1_done, d1_err_imm, d1_err_full;
    logic [1:0]  d1_mem_addr;
    logic [31:0] d1_mem_wdata;
    logic [2:0]  d1_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .req_valid(req_valid), .req_ready(d0_req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
        .mem_ready(mem_ready), .count(d0_count), .busy(d0_busy), .done(d0_done),
        .err_imm(d0_err_imm), .err_full(d0_err_full)
    );

    instr_encoder_loader #(.ADDR_W(2), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .req_valid(req_valid), .req_ready(d1_req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_ready(mem_ready), .count(d1_count), .busy(d1_busy), .done(d1_done),
        .err_imm(d1_err_imm), .err_full(d1_err_full)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic o_ready(input int sel);
        return (sel == 0) ? d0_req_ready : d1_req_ready;
    endfunction
    function automatic logic o_we(input int sel);
        return (sel == 0) ? d0_mem_we : d1_mem_we;
    endfunction
    function automatic logic [7:0] o_addr(input int sel);
        return (sel == 0) ? d0_mem_addr : 8'(d1_mem_addr);
    endfunction
    function automatic logic [31:0] o_wdata(input int sel);
        return (sel == 0) ? d0_mem_wdata : d1_mem_wdata;
    endfunction
    function automatic logic [8:0] o_count(input int sel);
        return (sel == 0) ? d0_count : 9'(d1_count);
    endfunction

    task automatic pulse_start(input int sel);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Present one request and hold it until the selected instance takes it
    task automatic send(input int sel, input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int k;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        k = 0;
        while (!o_ready(sel) && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) check("req_ready_timeout", 64'(o_ready(sel)), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the cycle after a handshake with mem_ready held high
    task automatic expect_write(input int sel, input string tag, input logic [7:0] addr,
                                input logic [31:0] data, input logic [8:0] cnt);
        check({tag, "_we"}, 64'(o_we(sel)), 64'd1);
        check({tag, "_addr"}, 64'(o_addr(sel)), 64'(addr));
        check({tag, "_wdata"}, 64'(o_wdata(sel)), 64'(data));
        tick();
        check({tag, "_we_drop"}, 64'(o_we(sel)), 64'd0);
        check({tag, "_count"}, 64'(o_count(sel)), 64'(cnt));
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_req_ready", 64'(d0_req_ready), 64'd0);
        check("rst_mem_we", 64'(d0_mem_we), 64'd0);
        check("rst_addr_wdata", {24'd0, d0_mem_addr, d0_mem_wdata}, 64'd0);
        check("rst_count", 64'(d0_count), 64'd0);
        check("rst_flags", 64'({d0_done, d0_busy, d0_err_imm, d0_err_full}), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(d0_req_ready), 64'd0);

        // ADD / SUB
        pulse_start(0);
        check("run_busy", 64'(d0_busy), 64'd1);
        check("run_ready", 64'(d0_req_ready), 64'd1);
        send(0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_write(0, "add", 8'd0, 32'h002081B3, 9'd1);
        check("add_ready_again", 64'(d0_req_ready), 64'd1);
        send(0, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_write(0, "sub", 8'd1, 32'h402081B3, 9'd2);

        // ADDI / LW / SW
        pulse_start(0);
        check("restart_count", 64'(d0_count), 64'd0);
        send(0, 3'd4, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        expect_write(0, "addi", 8'd0, 32'hFFF00293, 9'd1);
        send(0, 3'd2, 5'd4, 5'd2, 5'd0, 32'd8);
        expect_write(0, "lw", 8'd1, 32'h00812203, 9'd2);
        send(0, 3'd3, 5'd0, 5'd2, 5'd4, 32'd12);
        expect_write(0, "sw", 8'd2, 32'h00412623, 9'd3);

        // LUI / JAL / HALT
        send(0, 3'd5, 5'd1, 5'd0, 5'd0, 32'h12345000);
        expect_write(0, "lui", 8'd3, 32'h123450B7, 9'd4);
        send(0, 3'd6, 5'd1, 5'd0, 5'd0, 32'd8);
        expect_write(0, "jal", 8'd4, 32'h008000EF, 9'd5);
        send(0, 3'd7, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF);
        expect_write(0, "halt", 8'd5, 32'h00000000, 9'd6);
        check("halt_done", 64'(d0_done), 64'd1);
        check("halt_ready", 64'(d0_req_ready), 64'd0);
        check("halt_busy", 64'(d0_busy), 64'd0);

        // Write stalled by mem_ready low for 3 cycles
        pulse_start(0);
        mem_ready = 1'b0;
        send(0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("stall_we", 64'(d0_mem_we), 64'd1);
            check("stall_addr", 64'(d0_mem_addr), 64'd0);
            check("stall_wdata", 64'(d0_mem_wdata), 64'h002081B3);
            check("stall_count", 64'(d0_count), 64'd0);
            mem_ready = (i == 3);
            tick();
        end
        check("stall_we_drop", 64'(d0_mem_we), 64'd0);
        check("stall_count_once", 64'(d0_count), 64'd1);

        // Out-of-range immediates
        send(0, 3'd4, 5'd5, 5'd0, 5'd0, 32'd2048);
        check("addi_err", 64'(d0_err_imm), 64'd1);
        check("addi_err_nowe", 64'(d0_mem_we), 64'd0);
        check("addi_err_ready", 64'(d0_req_ready), 64'd1);
        check("addi_err_count", 64'(d0_count), 64'd1);

        // start with a coincident request: request ignored, errors cleared
        req_op = 3'd0; req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_valid = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        req_valid = 1'b0;
        check("start_clr_err", 64'(d0_err_imm), 64'd0);
        check("start_no_accept", 64'(d0_mem_we), 64'd0);
        check("start_count", 64'(d0_count), 64'd0);
        tick();
        check("start_no_accept2", 64'(d0_mem_we), 64'd0);

        send(0, 3'd5, 5'd1, 5'd0, 5'd0, 32'h00001001);
        check("lui_err", 64'(d0_err_imm), 64'd1);
        check("lui_err_nowe", 64'(d0_mem_we), 64'd0);
        check("lui_err_count", 64'(d0_count), 64'd0);
        send(0, 3'd6, 5'd1, 5'd0, 5'd0, 32'd6);
        expect_write(0, "jal_ok", 8'd0, 32'h006000EF, 9'd1);
        send(0, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0);
        expect_write(0, "halt2", 8'd1, 32'h0, 9'd2);
        check("halt2_err_sticky", 64'(d0_err_imm), 64'd1);

        // DEPTH=4 instance fills without HALT
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
            expect_write(1, "fill", 8'(i), 32'h002081B3, 9'(i + 1));
        end
        check("full_done", 64'(d1_done), 64'd1);
        check("full_err", 64'(d1_err_full), 64'd1);
        check("full_ready", 64'(d1_req_ready), 64'd0);
        pulse_start(1);
        check("full_err_clr", 64'(d1_err_full), 64'd0);
        check("full_count_clr", 64'(d1_count), 64'd0);

        // start during a stalled write abandons it
        mem_ready = 1'b0;
        send(1, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        check("abort_we", 64'(d1_mem_we), 64'd1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("abort_we_drop", 64'(d1_mem_we), 64'd0);
        check("abort_count", 64'(d1_count), 64'd0);
        check("abort_state_run", 64'({d1_busy, d1_req_ready}), 64'd3);

        // rst during a stalled write takes effect immediately
        send(1, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        check("rst_mid_we", 64'(d1_mem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_we_drop", 64'(d1_mem_we), 64'd0);
        check("rst_mid_wdata", 64'(d1_mem_wdata), 64'd0);
        check("rst_mid_flags", 64'({d1_busy, d1_done, d1_req_ready}), 64'd0);
        check("rst_mid_count", 64'(d1_count), 64'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes field-level instruction requests (op, rd, rs1, rs2, imm) into 32-bit RV32I-format words for the instruction set the CPU decodes: ADD, SUB, LW, SW, ADDI, LUI, JAL, plus a HALT/stop word. It writes each encoded word sequentially into instruction memory through a handshaked write port. It sits between the testbench or boot sequencer and instruction memory, and preloads programs before the core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of writable words (must be at most 2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  1-cycle pulse; restarts loading at word address 0
req_valid  input  1  request present
req_ready  output  1  encoder accepts the request this cycle
req_op  input  3  0 ADD, 1 SUB, 2 LW, 3 SW, 4 ADDI, 5 LUI, 6 JAL, 7 HALT
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_imm  input  32  immediate, full-width signed value
mem_we  output  1  write request to instruction memory
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  encoded instruction word
mem_ready  input  1  memory accepts the write this cycle
count  output  ADDR_W+1  number of words written since start
busy  output  1  state is RUN or WRITE
done  output  1  state is DONE
err_imm  output  1  sticky; an immediate was out of range
err_full  output  1  sticky; memory filled without HALT

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err_imm=0, err_full=0, busy=0.
- FSM states: IDLE, RUN, WRITE, DONE.
- IDLE:
  - req_ready=0.
  - start moves the FSM to RUN with ptr=0 and count=0.
- RUN:
  - req_ready=1.
  - On handshake (req_valid & req_ready), the encoded word is registered into mem_wdata and the FSM goes to WRITE the next cycle.
- WRITE:
  - mem_we=1, mem_addr=ptr; mem_wdata is held stable until mem_ready=1.
  - On mem_ready: ptr and count increment.
  - Next state is DONE if the op was HALT, or if count becomes DEPTH. In the DEPTH case, err_full is set when the op was not HALT.
  - Otherwise next state is RUN.
- Latency: handshake in cycle N gives mem_we=1 in N+1. With mem_ready=1 in N+1, req_ready=1 again in N+2. Peak rate is one instruction per 2 cycles.
- DONE:
  - req_ready=0, mem_we=0, done=1.
  - Held until start or rst.
- start in any state (including mid-WRITE):
  - Next cycle state=RUN, ptr=0, count=0, errors cleared, mem_we=0.
  - Any pending write is abandoned.
  - A req_valid coincident with start is not accepted.
- Encodings, opcode in [6:0]:
  - ADD: {0000000, rs2, rs1, 000, rd, 0110011}.
  - SUB: same with funct7 = 0100000.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - ADDI: {imm[11:0], rs1, 000, rd, 0010011}.
  - LUI: {imm[31:12], rd, 0110111}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - HALT: 32'h0000_0000.
- Unused fields for an op are ignored; they are never merged into the word.
- Immediate range checks:
  - LW/SW/ADDI: req_imm[31:11] must be all-equal (signed 12-bit).
  - LUI: req_imm[11:0] must be 0.
  - JAL: req_imm[0] must be 0 and req_imm[31:20] must be all-equal.
- On a violation the request is still handshaked, err_imm is set, nothing is written, count is unchanged, and the FSM stays in RUN.

Test Plan:
- start, then ADD rd=3 rs1=1 rs2=2, mem_ready=1 -> mem_we 1 cycle, addr 0, wdata 0x002081B3, count=1; SUB with the same fields -> addr 1, 0x402081B3.
- ADDI rd=5 rs1=0 imm=-1; LW rd=4 rs1=2 imm=8; SW rs2=4 rs1=2 imm=12 -> 0xFFF00293, 0x00812203, 0x00412623 at addrs 0-2.
- LUI rd=1 imm=0x12345000; JAL rd=1 imm=8; HALT -> 0x123450B7, 0x008000EF, 0x00000000; then done=1 and req_ready=0.
- mem_ready held low 3 cycles during WRITE -> mem_we, mem_addr and mem_wdata stable for 4 cycles; exactly one count increment.
- ADDI imm=2048, then LUI imm=0x00001001 -> err_imm=1, no mem_we, count unchanged; start clears err_imm.
- DEPTH=4 instance, 4 ADDs without HALT -> DONE, err_full=1, count=4; start asserted mid-WRITE -> mem_we drops next cycle, count=0, state RUN; rst asserted mid-WRITE -> outputs at reset values immediately.
